// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S sample FIFO.
package i2s_pkg;

  localparam int unsigned I2S_CH_W      = 24;
  localparam int unsigned I2S_FRAME_W   = 48;
  localparam int unsigned I2S_LEFT_MSB  = 47;
  localparam int unsigned I2S_RIGHT_MSB = 23;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned i2s_clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/i2s_fifo_mem.sv
// DEPTH x 48 frame storage: one synchronous write port, one asynchronous read port.
module i2s_fifo_mem
  import i2s_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [I2S_FRAME_W-1:0] wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [I2S_FRAME_W-1:0] rdata
);

  logic [I2S_FRAME_W-1:0] mem [DEPTH];

  // Write port; contents need no reset since reads are masked while empty.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read port.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/i2s_sample_fifo.sv
// Stereo frame FIFO feeding the I2S master, first-word-fall-through.
// Optional almost-empty interrupt enabled by defining I2S_SAMPLE_FIFO_AE_IRQ_EN.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned LVL_W     = $clog2(DEPTH) + 1,
  parameter int unsigned AE_THRESH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [I2S_FRAME_W-1:0] wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [I2S_FRAME_W-1:0] fifo_data,
  output logic                   fifo_valid,
  input  logic                   fifo_ready,
  output logic [LVL_W-1:0]       level,
  output logic                   empty,
  output logic                   full,
  output logic                   irq_ae
);

  localparam int unsigned PTR_W = i2s_clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AE_THRESH < 1 || AE_THRESH > DEPTH)
  begin : g_cfg_err
    $error("i2s_sample_fifo: bad DEPTH/AE_THRESH configuration");
  end

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   push, pop;
  logic [I2S_FRAME_W-1:0] rd_frame;

  // Status flags come only from the registered level, so wr_ready never
  // depends on the consumer's pop in the same cycle.
  always_comb begin
    empty      = (level_q == '0);
    full       = (level_q == LVL_W'(DEPTH));
    wr_ready   = !full;
    fifo_valid = !empty;
    level      = level_q;
    fifo_data  = empty ? '0 : rd_frame;
    push       = wr_valid && !full;
    pop        = fifo_ready && !empty;
  end

  // Next-state for pointers and level; flush overrides any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  i2s_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_frame)
  );

`ifdef I2S_SAMPLE_FIFO_AE_IRQ_EN
  logic ae_cross_q, irq_q;

  // ae_cross_q marks the edge where level fell from AE_THRESH to AE_THRESH-1;
  // the interrupt follows one cycle later and clears once level recovers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ae_cross_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ae_cross_q <= !flush && (level_q == LVL_W'(AE_THRESH)) &&
                    (level_d == LVL_W'(AE_THRESH - 1));
      if (flush || level_q >= LVL_W'(AE_THRESH)) irq_q <= 1'b0;
      else if (ae_cross_q)                       irq_q <= 1'b1;
    end
  end

  // Registered interrupt level.
  always_comb begin
    irq_ae = irq_q;
  end
`else
  // Feature disabled: no threshold logic.
  always_comb begin
    irq_ae = 1'b0;
  end
`endif

endmodule
